// File: rtl/rx_pack_pkg.sv
// rtl/rx_pack_pkg.sv - shared types, size encodings and helpers for the rx FIFO read controller
package rx_pack_pkg;

  localparam int RX_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] SZ_1B   = 2'b00;
  localparam logic [1:0] SZ_2B   = 2'b01;
  localparam logic [1:0] SZ_4B   = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Reserved encoding maps to 0 bytes so callers can treat it as "reject".
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_1B:   return 3'd1;
      SZ_2B:   return 3'd2;
      SZ_4B:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rx_occ_counter.sv
// rtl/rx_occ_counter.sv - saturating up/down shadow occupancy counter for the rx FIFO
// Ports: clk, n_rst (async active-low), inc (FIFO write), dec (FIFO pop), count (bytes held).
module rx_occ_counter
  import rx_pack_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  // A write while full is dropped by the FIFO, so it is not counted.
  // A write and pop in the same cycle cancel out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (inc && !dec && (count < CNT_W'(DEPTH))) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/rx_pack_ctrl.sv
// rtl/rx_pack_ctrl.sv - rx FIFO read controller packing 1/2/4 popped bytes into a 32-bit host word
// Build option: RX_PACK_BE_EN selects big-endian right-aligned packing (default little-endian).
// Ports: clk, n_rst (async active-low); rx_w_enable (FIFO write copy), fifo_empty, fifo_r_data,
//        fifo_r_enable (pop); host_req, host_size, host_flush (requests); host_data, host_valid,
//        host_err (results); busy (not IDLE); occupancy (shadow byte count).
module rx_pack_ctrl
  import rx_pack_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             rx_w_enable,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_r_data,
  output logic             fifo_r_enable,
  input  logic             host_req,
  input  logic [1:0]       host_size,
  input  logic             host_flush,
  output logic [31:0]      host_data,
  output logic             host_valid,
  output logic             host_err,
  output logic             busy,
  output logic [CNT_W-1:0] occupancy
);

  state_t     state, state_nxt;
  logic [1:0] idx;
  logic [2:0] remaining;
  logic [2:0] req_bytes;
  logic       req_bad;
  logic [1:0] lane;

  assign req_bytes = size_to_bytes(host_size);
  // Reject before any pop: reserved size, or fewer bytes buffered than asked for.
  assign req_bad   = (req_bytes == 3'd0) || (occupancy < CNT_W'(req_bytes));

`ifdef RX_PACK_BE_EN
  // Byte k of N lands in lane N-1-k, which is exactly remaining-1 at that pop.
  assign lane = 2'(remaining - 3'd1);
`else
  assign lane = idx;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fifo_r_enable = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (host_flush) begin
          state_nxt = FLUSH;
        end else if (host_req && !req_bad) begin
          state_nxt = POP;
        end
      end
      POP: begin
        fifo_r_enable = !fifo_empty;
        if (!fifo_empty && (remaining == 3'd1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      FLUSH: begin
        fifo_r_enable = !fifo_empty;
        if (fifo_empty) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      host_data  <= '0;
      host_valid <= 1'b0;
      host_err   <= 1'b0;
      idx        <= '0;
      remaining  <= '0;
    end else begin
      host_valid <= 1'b0;
      host_err   <= 1'b0;
      if ((state == IDLE) && !host_flush && host_req) begin
        if (req_bad) begin
          host_err <= 1'b1;
        end else begin
          remaining <= req_bytes;
          idx       <= '0;
          host_data <= '0;
        end
      end
      if ((state == POP) && !fifo_empty) begin
        host_data[{lane, 3'b000} +: 8] <= fifo_r_data;
        idx       <= idx + 2'd1;
        remaining <= remaining - 3'd1;
        // Registered so the pulse coincides with the DONE cycle.
        if (remaining == 3'd1) begin
          host_valid <= 1'b1;
        end
      end
    end
  end

  rx_occ_counter #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_occ (
    .clk  (clk),
    .n_rst(n_rst),
    .inc  (rx_w_enable),
    .dec  (fifo_r_enable),
    .count(occupancy)
  );

endmodule

// File: tb/tb_rx_pack_ctrl.sv
// tb/tb_rx_pack_ctrl.sv - scoreboard bench for rx_pack_ctrl with a behavioural 64-byte FIFO
module tb_rx_pack_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rx_w_enable;
  logic        fifo_empty;
  logic [7:0]  fifo_r_data;
  logic        fifo_r_enable;
  logic        host_req;
  logic [1:0]  host_size;
  logic        host_flush;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_err;
  logic        busy;
  logic [6:0]  occupancy;

  always #5 clk = ~clk;

  rx_pack_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_w_enable  (rx_w_enable),
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_r_enable(fifo_r_enable),
    .host_req     (host_req),
    .host_size    (host_size),
    .host_flush   (host_flush),
    .host_data    (host_data),
    .host_valid   (host_valid),
    .host_err     (host_err),
    .busy         (busy),
    .occupancy    (occupancy)
  );

  // Behavioural FIFO, first-word-fall-through, drops writes when full.
  logic [7:0] mem [0:63];
  logic [5:0] wp, rp;
  logic [6:0] cnt;
  logic [7:0] wdata;
  logic       do_w, do_r;

  assign do_w        = rx_w_enable && (cnt < 7'd64);
  assign do_r        = fifo_r_enable && (cnt != 7'd0);
  assign fifo_empty  = (cnt == 7'd0);
  assign fifo_r_data = fifo_empty ? 8'h00 : mem[rp];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_w) begin
        mem[wp] <= wdata;
        wp      <= wp + 6'd1;
      end
      if (do_r) rp <= rp + 6'd1;
      cnt <= cnt + {6'd0, do_w} - {6'd0, do_r};
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int pop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (n_rst && fifo_r_enable) pop_cnt++;
    if (n_rst && (host_valid || host_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, host_valid, host_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_kind", {30'd0, host_valid, host_err}, e.err ? 32'd1 : 32'd2);
        chk("resp_data", host_data, e.data);
      end
    end
  end

  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0]  b [4];
    logic [31:0] r;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    r = '0;
    for (int k = 0; k < n; k++) begin
`ifdef RX_PACK_BE_EN
      r[(n-1-k)*8 +: 8] = b[k];
`else
      r[k*8 +: 8] = b[k];
`endif
    end
    return r;
  endfunction

  logic [31:0] last_data = 32'd0;

  task automatic push_exp(input logic err, input logic [31:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    if (!err) last_data = data;
    exp_q.push_back(e);
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    rx_w_enable = 1'b1;
    wdata       = b;
    @(negedge clk);
    rx_w_enable = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 200) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic request(input logic [1:0] size);
    @(negedge clk);
    host_req  = 1'b1;
    host_size = size;
    @(negedge clk);
    host_req  = 1'b0;
    wait_idle();
  endtask

  initial begin
    n_rst       = 1'b0;
    rx_w_enable = 1'b0;
    wdata       = 8'h00;
    host_req    = 1'b0;
    host_size   = 2'b00;
    host_flush  = 1'b0;
    #12;
    chk("rst_host_data", host_data, 32'd0);
    chk("rst_valid", {31'd0, host_valid}, 32'd0);
    chk("rst_err", {31'd0, host_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_r_enable}, 32'd0);
    chk("rst_occ", {25'd0, occupancy}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // 4-byte request with cycle-exact timing.
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    chk("occ_after_4w", {25'd0, occupancy}, 32'd4);
    push_exp(1'b0, pack(8'h11, 8'h22, 8'h33, 8'h44, 4));
    @(negedge clk);
    host_req  = 1'b1;
    host_size = 2'b10;
    @(negedge clk);
    host_req  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("rd_en_cycle%0d", k), {31'd0, fifo_r_enable}, 32'd1);
      chk($sformatf("no_valid_cycle%0d", k), {31'd0, host_valid}, 32'd0);
      @(negedge clk);
    end
    chk("valid_cycle5", {31'd0, host_valid}, 32'd1);
    @(negedge clk);
    chk("busy_after_4b", {31'd0, busy}, 32'd0);
    chk("occ_after_4b", {25'd0, occupancy}, 32'd0);

    // Underflow reject: 1 byte held, 2 requested.
    write_byte(8'h77);
    pop_cnt = 0;
    push_exp(1'b1, last_data);
    request(2'b01);
    chk("underflow_no_pop", pop_cnt, 32'd0);
    chk("underflow_occ", {25'd0, occupancy}, 32'd1);

    // Reserved size reject with 4 held.
    write_byte(8'h88); write_byte(8'h99); write_byte(8'hAA);
    push_exp(1'b1, last_data);
    request(2'b11);
    chk("rsvd_occ", {25'd0, occupancy}, 32'd4);

    // 2-byte then two 1-byte requests drain the FIFO.
    push_exp(1'b0, pack(8'h77, 8'h88, 8'h00, 8'h00, 2));
    request(2'b01);
    push_exp(1'b0, 32'h0000_0099);
    request(2'b00);
    push_exp(1'b0, 32'h0000_00AA);
    request(2'b00);
    chk("occ_after_drain", {25'd0, occupancy}, 32'd0);

    // Flush of 10 bytes; a host_req issued mid-flush is ignored.
    for (int i = 0; i < 10; i++) write_byte(8'(8'hC0 + i));
    pop_cnt = 0;
    @(negedge clk);
    host_flush = 1'b1;
    @(negedge clk);
    host_flush = 1'b0;
    @(negedge clk);
    host_req  = 1'b1;
    host_size = 2'b00;
    @(negedge clk);
    host_req  = 1'b0;
    wait_idle();
    chk("flush_pops", pop_cnt, 32'd10);
    chk("flush_occ", {25'd0, occupancy}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);

    // Saturation at 64, then simultaneous write and pop.
    for (int i = 0; i < 65; i++) write_byte(8'(i));
    chk("occ_saturate", {25'd0, occupancy}, 32'd64);
    push_exp(1'b0, 32'h0000_0000);
    request(2'b00);
    chk("occ_63", {25'd0, occupancy}, 32'd63);
    push_exp(1'b0, 32'h0000_0001);
    @(negedge clk);
    host_req  = 1'b1;
    host_size = 2'b00;
    @(negedge clk);
    host_req    = 1'b0;
    rx_w_enable = 1'b1;
    wdata       = 8'hEE;
    chk("simul_rd_en", {31'd0, fifo_r_enable}, 32'd1);
    @(negedge clk);
    rx_w_enable = 1'b0;
    chk("occ_simul", {25'd0, occupancy}, 32'd63);
    wait_idle();
    pop_cnt = 0;
    @(negedge clk);
    host_flush = 1'b1;
    @(negedge clk);
    host_flush = 1'b0;
    wait_idle();
    chk("flush63_pops", pop_cnt, 32'd63);
    chk("flush63_occ", {25'd0, occupancy}, 32'd0);

    // Reset in the middle of a 4-byte request after one pop.
    write_byte(8'hA1); write_byte(8'hA2); write_byte(8'hA3); write_byte(8'hA4);
    @(negedge clk);
    host_req  = 1'b1;
    host_size = 2'b10;
    @(negedge clk);
    host_req = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_data", host_data, 32'd0);
    chk("mid_rst_valid", {31'd0, host_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, host_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rd_en", {31'd0, fifo_r_enable}, 32'd0);
    chk("mid_rst_occ", {25'd0, occupancy}, 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
    write_byte(8'h5A);
    push_exp(1'b0, 32'h0000_005A);
    request(2'b00);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
